// File: rtl/hash_round_ctrl.sv
// Round sequencer for an external mux-cell hash datapath: load, ROUNDS rounds, capture, handshake.
// Optional abort input in LOAD/ROUND is enabled by defining HASH_CTRL_ABORT_EN.
module hash_round_ctrl #(
  parameter int unsigned W      = 8,
  parameter int unsigned ROUNDS = 8
) (
  input  logic         clk,
  input  logic         clr,
`ifdef HASH_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] msg_in,
  output logic         dp_load,
  output logic [W-1:0] dp_d,
  output logic         dp_en,
  output logic         sel_a1,
  output logic         sel_b1,
  output logic         sel_a0,
  output logic         sel_b0,
  input  logic [W-1:0] dp_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] hash_out,
  output logic [7:0]   round
);

  localparam logic [7:0] LastRound = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

  state_e         state_q, state_d;
  logic [7:0]     round_q, round_d;
  logic [W-1:0]   dp_d_q, dp_d_d;
  logic [W-1:0]   hash_q, hash_d;
  logic           captured_q, captured_d;
  logic           valid_q, valid_d;
  logic           abort_hit;

`ifdef HASH_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    dp_d_d     = dp_d_q;
    hash_d     = hash_q;
    captured_d = captured_q;
    valid_d    = valid_q;
    in_ready   = 1'b0;
    dp_load    = 1'b0;
    dp_en      = 1'b0;
    sel_a1     = 1'b0;
    sel_b1     = 1'b0;
    sel_a0     = 1'b0;
    sel_b0     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready   = 1'b1;
        round_d    = 8'd0;
        captured_d = 1'b0;
        valid_d    = 1'b0;
        if (in_valid) begin
          state_d = StLoad;
          dp_d_d  = msg_in;
        end
      end
      StLoad: begin
        dp_load = 1'b1;
        round_d = 8'd0;
        state_d = abort_hit ? StIdle : StRound;
      end
      StRound: begin
        dp_en  = 1'b1;
        // Cell select {s1,s0} = {a1|b1, a0&b0} walks round[1:0].
        sel_a1 = round_q[1];
        sel_a0 = round_q[0];
        sel_b0 = round_q[0];
        if (abort_hit) begin
          state_d = StIdle;
          round_d = 8'd0;
        end else if (round_q == LastRound) begin
          state_d = StDone;
          round_d = 8'd0;
        end else begin
          round_d = round_q + 8'd1;
        end
      end
      StDone: begin
        // Capture on the first DONE edge, raise out_valid on the next.
        if (!captured_q) begin
          hash_d     = dp_q;
          captured_d = 1'b1;
        end else if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          state_d    = StIdle;
          valid_d    = 1'b0;
          captured_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      round_q    <= 8'd0;
      dp_d_q     <= '0;
      hash_q     <= '0;
      captured_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      dp_d_q     <= dp_d_d;
      hash_q     <= hash_d;
      captured_q <= captured_d;
      valid_q    <= valid_d;
    end
  end

  assign round     = round_q;
  assign dp_d      = dp_d_q;
  assign hash_out  = hash_q;
  assign out_valid = valid_q;

endmodule
